// File: rtl/comparator_seq_ctrl.sv
// Iterative wide-operand magnitude compare controller: walks operand nibbles MSB-first through an
// external comparator_4b, chaining its cascade inputs from the previous nibble's registered result.
module comparator_seq_ctrl #(
  parameter int WIDTH      = 16,
  parameter bit EARLY_EXIT = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start_valid,
  output logic             start_ready,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  output logic [3:0]       nib_a,
  output logic [3:0]       nib_b,
  output logic             casc_l,
  output logic             casc_g,
  output logic             casc_m,
  input  logic             cmp_l,
  input  logic             cmp_g,
  input  logic             cmp_m,
  output logic             res_valid,
  input  logic             res_ready,
  output logic             res_l,
  output logic             res_g,
  output logic             res_m,
  output logic             err
);

  localparam int NIB = WIDTH / 4;
  localparam int IW  = (NIB > 1) ? $clog2(NIB) : 1;
  localparam logic [IW-1:0] IDX_LAST = IW'(NIB - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state;
  logic [WIDTH-1:0] a_reg;
  logic [WIDTH-1:0] b_reg;
  logic [IW-1:0]    idx;
  logic [IW+1:0]    bit_base;
  logic [WIDTH-1:0] a_shift;
  logic [WIDTH-1:0] b_shift;
  logic             one_hot;
  logic             decided;

  // Shift rather than indexed part-select keeps the select width independent of WIDTH.
  assign bit_base = {idx, 2'b00};
  assign a_shift  = a_reg >> bit_base;
  assign b_shift  = b_reg >> bit_base;

  always_comb begin
    nib_a = 4'h0;
    nib_b = 4'h0;
    if (state == RUN) begin
      nib_a = a_shift[3:0];
      nib_b = b_shift[3:0];
    end
  end

  assign one_hot = ({cmp_l, cmp_g, cmp_m} == 3'b100) ||
                   ({cmp_l, cmp_g, cmp_m} == 3'b010) ||
                   ({cmp_l, cmp_g, cmp_m} == 3'b001);
  assign decided = (idx == '0) || (EARLY_EXIT && (cmp_l || cmp_m));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      a_reg       <= '0;
      b_reg       <= '0;
      idx         <= '0;
      casc_l      <= 1'b0;
      casc_g      <= 1'b0;
      casc_m      <= 1'b0;
      res_l       <= 1'b0;
      res_g       <= 1'b0;
      res_m       <= 1'b0;
      res_valid   <= 1'b0;
      err         <= 1'b0;
      start_ready <= 1'b1;
    end else begin
      case (state)
        IDLE: begin
          if (start_valid) begin
            a_reg       <= op_a;
            b_reg       <= op_b;
            idx         <= IDX_LAST;
            casc_l      <= 1'b0;
            casc_g      <= 1'b1;
            casc_m      <= 1'b0;
            err         <= 1'b0;
            start_ready <= 1'b0;
            state       <= RUN;
          end
        end
        RUN: begin
          casc_l <= cmp_l;
          casc_g <= cmp_g;
          casc_m <= cmp_m;
          err    <= err | ~one_hot;
          if (decided) begin
            res_l     <= cmp_l;
            res_g     <= cmp_g;
            res_m     <= cmp_m;
            res_valid <= 1'b1;
            state     <= DONE;
          end else begin
            idx <= idx - 1'b1;
          end
        end
        DONE: begin
          // start_ready stays low here, so no accept can overlap the result handshake.
          if (res_ready) begin
            res_valid   <= 1'b0;
            start_ready <= 1'b1;
            state       <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_comparator_seq_ctrl.sv
// Directed bench for comparator_seq_ctrl: two instances (EARLY_EXIT=1 and 0) share stimulus,
// each driven by its own behavioural comparator_4b model on the cascade path.
module tb_comparator_seq_ctrl;

  logic        clk;
  logic        rst_n;
  logic        start_valid;
  logic        res_ready;
  logic [15:0] op_a;
  logic [15:0] op_b;
  logic        force_en;

  logic       sr1, cl1, cg1, cm1, kl1, kg1, km1, rv1, rl1, rg1, rm1, er1;
  logic [3:0] na1, nb1;
  logic       sr0, cl0, cg0, cm0, kl0, kg0, km0, rv0, rl0, rg0, rm0, er0;
  logic [3:0] na0, nb0;

  int n_cmp;
  int n_bad;

  int         lat1, lat0;
  logic [2:0] r1, r0;
  logic       e1, e0;

  function automatic logic [2:0] cmp_model(input logic [3:0] a, input logic [3:0] b,
                                           input logic l, input logic g, input logic m);
    return {l | (g & (a > b)), g & (a == b), m | (g & (a < b))};
  endfunction

  assign {kl1, kg1, km1} = force_en ? 3'b110 : cmp_model(na1, nb1, cl1, cg1, cm1);
  assign {kl0, kg0, km0} = cmp_model(na0, nb0, cl0, cg0, cm0);

  comparator_seq_ctrl #(.WIDTH(16), .EARLY_EXIT(1'b1)) dut1 (
    .clk(clk), .rst_n(rst_n), .start_valid(start_valid), .start_ready(sr1),
    .op_a(op_a), .op_b(op_b), .nib_a(na1), .nib_b(nb1),
    .casc_l(cl1), .casc_g(cg1), .casc_m(cm1), .cmp_l(kl1), .cmp_g(kg1), .cmp_m(km1),
    .res_valid(rv1), .res_ready(res_ready), .res_l(rl1), .res_g(rg1), .res_m(rm1), .err(er1)
  );

  comparator_seq_ctrl #(.WIDTH(16), .EARLY_EXIT(1'b0)) dut0 (
    .clk(clk), .rst_n(rst_n), .start_valid(start_valid), .start_ready(sr0),
    .op_a(op_a), .op_b(op_b), .nib_a(na0), .nib_b(nb0),
    .casc_l(cl0), .casc_g(cg0), .casc_m(cm0), .cmp_l(kl0), .cmp_g(kg0), .cmp_m(km0),
    .res_valid(rv0), .res_ready(res_ready), .res_l(rl0), .res_g(rg0), .res_m(rm0), .err(er0)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Accept one pair, then watch 12 cycles recording the first res_valid cycle per instance.
  task automatic run(input logic [15:0] a, input logic [15:0] b, input bit inj);
    op_a = a;
    op_b = b;
    start_valid = 1'b1;
    step();
    start_valid = 1'b0;
    force_en = inj;
    lat1 = 0; lat0 = 0; r1 = '0; r0 = '0; e1 = 1'b0; e0 = 1'b0;
    for (int c = 1; c <= 12; c++) begin
      if (rv1 && lat1 == 0) begin lat1 = c; r1 = {rl1, rg1, rm1}; e1 = er1; end
      if (rv0 && lat0 == 0) begin lat0 = c; r0 = {rl0, rg0, rm0}; e0 = er0; end
      step();
      force_en = 1'b0;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #12;
    n_cmp++; if (sr1 !== 1'b1) begin n_bad++; $display("FAIL reset_start_ready got %b want 1", sr1); end
    n_cmp++; if (rv1 !== 1'b0) begin n_bad++; $display("FAIL reset_res_valid got %b want 0", rv1); end
    n_cmp++; if ({na1, nb1} !== 8'h00) begin n_bad++; $display("FAIL reset_nibs got %h want 00", {na1, nb1}); end
    n_cmp++; if ({cl1, cg1, cm1, rl1, rg1, rm1, er1} !== 7'b0) begin
      n_bad++; $display("FAIL reset_casc_res_err got %b want 0000000", {cl1, cg1, cm1, rl1, rg1, rm1, er1}); end
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_equal();
    run(16'h1234, 16'h1234, 1'b0);
    n_cmp++; if (lat1 !== 5) begin n_bad++; $display("FAIL equal_lat_ee1 got %0d want 5", lat1); end
    n_cmp++; if (r1 !== 3'b010) begin n_bad++; $display("FAIL equal_res_ee1 got %b want 010", r1); end
    n_cmp++; if (e1 !== 1'b0) begin n_bad++; $display("FAIL equal_err_ee1 got %b want 0", e1); end
    n_cmp++; if (lat0 !== 5 || r0 !== 3'b010) begin
      n_bad++; $display("FAIL equal_ee0 got lat %0d res %b want lat 5 res 010", lat0, r0); end
  endtask

  task automatic test_early_exit();
    run(16'h8000, 16'h7FFF, 1'b0);
    n_cmp++; if (lat1 !== 2 || r1 !== 3'b100) begin
      n_bad++; $display("FAIL early_msb_ee1 got lat %0d res %b want lat 2 res 100", lat1, r1); end
    n_cmp++; if (lat0 !== 5 || r0 !== 3'b100) begin
      n_bad++; $display("FAIL early_msb_ee0 got lat %0d res %b want lat 5 res 100", lat0, r0); end
    run(16'h00F0, 16'h0100, 1'b0);
    n_cmp++; if (lat1 !== 3 || r1 !== 3'b001) begin
      n_bad++; $display("FAIL early_nib2_ee1 got lat %0d res %b want lat 3 res 001", lat1, r1); end
    n_cmp++; if (lat0 !== 5 || r0 !== 3'b001) begin
      n_bad++; $display("FAIL early_nib2_ee0 got lat %0d res %b want lat 5 res 001", lat0, r0); end
  endtask

  task automatic test_full_run();
    run(16'h0001, 16'h0002, 1'b0);
    n_cmp++; if (lat1 !== 5 || r1 !== 3'b001) begin
      n_bad++; $display("FAIL lsb_less_ee1 got lat %0d res %b want lat 5 res 001", lat1, r1); end
    n_cmp++; if (lat0 !== 5 || r0 !== 3'b001) begin
      n_bad++; $display("FAIL lsb_less_ee0 got lat %0d res %b want lat 5 res 001", lat0, r0); end
    run(16'hABCD, 16'hABCC, 1'b0);
    n_cmp++; if (lat1 !== 5 || r1 !== 3'b100 || e1 !== 1'b0) begin
      n_bad++; $display("FAIL lsb_greater_ee1 got lat %0d res %b err %b want lat 5 res 100 err 0", lat1, r1, e1); end
    n_cmp++; if (lat0 !== 5 || r0 !== 3'b100) begin
      n_bad++; $display("FAIL lsb_greater_ee0 got lat %0d res %b want lat 5 res 100", lat0, r0); end
  endtask

  task automatic test_stall();
    int waited;
    res_ready = 1'b0;
    op_a = 16'h5000;
    op_b = 16'h4000;
    start_valid = 1'b1;
    step();
    start_valid = 1'b0;
    waited = 0;
    while (!rv1 && waited < 12) begin step(); waited++; end
    n_cmp++; if (rv1 !== 1'b1) begin n_bad++; $display("FAIL stall_reach_done got %b want 1", rv1); end
    for (int i = 0; i < 10; i++) begin
      start_valid = i[0];
      op_a = 16'h0F0F;
      op_b = 16'hF0F0;
      n_cmp++; if (rv1 !== 1'b1) begin n_bad++; $display("FAIL stall_valid[%0d] got %b want 1", i, rv1); end
      n_cmp++; if ({rl1, rg1, rm1} !== 3'b100) begin
        n_bad++; $display("FAIL stall_res[%0d] got %b want 100", i, {rl1, rg1, rm1}); end
      n_cmp++; if (sr1 !== 1'b0) begin n_bad++; $display("FAIL stall_start_ready[%0d] got %b want 0", i, sr1); end
      step();
    end
    start_valid = 1'b0;
    res_ready = 1'b1;
    step();
    n_cmp++; if (rv1 !== 1'b0 || sr1 !== 1'b1) begin
      n_bad++; $display("FAIL stall_release got valid %b ready %b want 0 1", rv1, sr1); end
    n_cmp++; if ({rl1, rg1, rm1} !== 3'b100) begin
      n_bad++; $display("FAIL stall_idle_hold got %b want 100", {rl1, rg1, rm1}); end
    n_cmp++; if ({na1, nb1} !== 8'h00) begin n_bad++; $display("FAIL idle_nibs got %h want 00", {na1, nb1}); end
    repeat (8) step();
  endtask

  task automatic test_async_reset();
    op_a = 16'h1234;
    op_b = 16'h1234;
    start_valid = 1'b1;
    step();
    start_valid = 1'b0;
    step();
    #2 rst_n = 1'b0;
    #1;
    n_cmp++; if (sr1 !== 1'b1 || rv1 !== 1'b0) begin
      n_bad++; $display("FAIL arst_handshake got ready %b valid %b want 1 0", sr1, rv1); end
    n_cmp++; if ({na1, nb1} !== 8'h00) begin n_bad++; $display("FAIL arst_nibs got %h want 00", {na1, nb1}); end
    n_cmp++; if ({cl1, cg1, cm1, rl1, rg1, rm1, er1} !== 7'b0) begin
      n_bad++; $display("FAIL arst_regs got %b want 0000000", {cl1, cg1, cm1, rl1, rg1, rm1, er1}); end
    #3 rst_n = 1'b1;
    step();
    run(16'h0001, 16'h0002, 1'b0);
    n_cmp++; if (lat1 !== 5 || r1 !== 3'b001 || lat0 !== 5 || r0 !== 3'b001) begin
      n_bad++; $display("FAIL arst_clean_run got lat %0d/%0d res %b/%b want 5/5 001/001", lat1, lat0, r1, r0); end
  endtask

  task automatic test_err();
    run(16'h1234, 16'h1234, 1'b1);
    n_cmp++; if (lat1 !== 2 || r1 !== 3'b110) begin
      n_bad++; $display("FAIL err_flow got lat %0d res %b want lat 2 res 110", lat1, r1); end
    n_cmp++; if (e1 !== 1'b1) begin n_bad++; $display("FAIL err_set got %b want 1", e1); end
    n_cmp++; if (er1 !== 1'b1) begin n_bad++; $display("FAIL err_sticky got %b want 1", er1); end
    n_cmp++; if (e0 !== 1'b0) begin n_bad++; $display("FAIL err_other_inst got %b want 0", e0); end
    op_a = 16'h1234;
    op_b = 16'h1234;
    start_valid = 1'b1;
    step();
    start_valid = 1'b0;
    n_cmp++; if (er1 !== 1'b0) begin n_bad++; $display("FAIL err_clear_on_accept got %b want 0", er1); end
    repeat (12) step();
  endtask

  task automatic test_back_to_back();
    op_a = 16'h8000;
    op_b = 16'h7FFF;
    start_valid = 1'b1;
    step();
    n_cmp++; if (sr1 !== 1'b0 || rv1 !== 1'b0) begin
      n_bad++; $display("FAIL b2b_run got ready %b valid %b want 0 0", sr1, rv1); end
    step();
    n_cmp++; if (rv1 !== 1'b1 || {rl1, rg1, rm1} !== 3'b100 || sr1 !== 1'b0) begin
      n_bad++; $display("FAIL b2b_done got valid %b res %b ready %b want 1 100 0", rv1, {rl1, rg1, rm1}, sr1); end
    op_a = 16'h0100;
    op_b = 16'h0200;
    step();
    n_cmp++; if (rv1 !== 1'b0 || sr1 !== 1'b1) begin
      n_bad++; $display("FAIL b2b_idle_gap got valid %b ready %b want 0 1", rv1, sr1); end
    step();
    start_valid = 1'b0;
    n_cmp++; if (sr1 !== 1'b0) begin n_bad++; $display("FAIL b2b_second_accept got %b want 0", sr1); end
    step();
    step();
    n_cmp++; if (rv1 !== 1'b1 || {rl1, rg1, rm1} !== 3'b001) begin
      n_bad++; $display("FAIL b2b_second_res got valid %b res %b want 1 001", rv1, {rl1, rg1, rm1}); end
    repeat (14) step();
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    start_valid = 1'b0;
    res_ready = 1'b1;
    force_en = 1'b0;
    op_a = '0;
    op_b = '0;
    test_reset();
    test_equal();
    test_early_exit();
    test_full_run();
    test_stall();
    test_async_reset();
    test_err();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
